// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for a single shared ALU.
//
// A request is accepted on a rising edge where reqN_valid and reqN_ready are
// both high. Accepted operands enter a stage-1 register. One edge later the
// ALU output and flags are captured on the shared response bus, and the
// matching respN_valid pulses for one cycle. ctrl_stall freezes every
// register and blocks new grants.
//
// Ports:
//   clock, reset                      rising-edge clock, synchronous active-high reset
//   reqN_valid                        request present (N = 0, 1)
//   reqN_operandA/B [31:0]            ALU operands
//   reqN_ALUopcode, reqN_shiftamt [4:0] opcode and shift amount
//   reqN_ready                        grant (combinational)
//   ctrl_stall                        freeze grants and pipeline
//   respN_valid                       response on the bus belongs to requester N
//   resp_data_result [31:0]           registered ALU result
//   resp_isNotEqual/isLessThan/overflow registered ALU flags
//   busy                              an accepted request has not yet been answered

module alu (
  input  logic [31:0] operandA,
  input  logic [31:0] operandB,
  input  logic [4:0]  opcode,
  input  logic [4:0]  shiftAmt,
  output logic [31:0] result,
  output logic        isNotEqual,
  output logic        isLessThan,
  output logic        overflow
);
  logic [31:0] sum;
  logic [31:0] diff;
  logic        addOvf;
  logic        subOvf;

  assign sum    = operandA + operandB;
  assign diff   = operandA - operandB;
  assign addOvf = (operandA[31] == operandB[31]) && (sum[31] != operandA[31]);
  assign subOvf = (operandA[31] != operandB[31]) && (diff[31] != operandA[31]);

  // Comparison flags always come from A - B; the sign corrected by overflow
  // gives a true signed less-than.
  assign isNotEqual = |diff;
  assign isLessThan = diff[31] ^ subOvf;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (opcode)
      5'd0: begin result = sum;  overflow = addOvf; end
      5'd1: begin result = diff; overflow = subOvf; end
      5'd2: result = operandA & operandB;
      5'd3: result = operandA | operandB;
      5'd4: result = operandA << shiftAmt;
      5'd5: result = $signed(operandA) >>> shiftAmt;
      default: result = '0;
    endcase
  end
endmodule

module alu_arbiter #(
  parameter int FIRST_PRIO = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [31:0] req0_operandA,
  input  logic [31:0] req0_operandB,
  input  logic [4:0]  req0_ALUopcode,
  input  logic [4:0]  req0_shiftamt,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_operandA,
  input  logic [31:0] req1_operandB,
  input  logic [4:0]  req1_ALUopcode,
  input  logic [4:0]  req1_shiftamt,
  output logic        req1_ready,
  input  logic        ctrl_stall,
  output logic        resp0_valid,
  output logic        resp1_valid,
  output logic [31:0] resp_data_result,
  output logic        resp_isNotEqual,
  output logic        resp_isLessThan,
  output logic        resp_overflow,
  output logic        busy
);
  // lastGrant names the requester granted most recently; resetting it to the
  // other requester makes FIRST_PRIO win the first tie.
  localparam logic LAST_GRANT_INIT = (FIRST_PRIO == 0);

  logic        lastGrant;
  logic        accept0;
  logic        accept1;
  logic        accept;

  logic        s1Valid;
  logic        s1Id;
  logic [31:0] s1OperandA;
  logic [31:0] s1OperandB;
  logic [4:0]  s1Opcode;
  logic [4:0]  s1ShiftAmt;

  logic [31:0] aluResult;
  logic        aluNotEqual;
  logic        aluLessThan;
  logic        aluOverflow;

  // Grant: a lone request wins immediately; a tie goes to whoever was not
  // granted last. Nothing is granted during reset or stall.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!reset && !ctrl_stall) begin
      if (req0_valid && req1_valid) begin
        req0_ready = lastGrant;
        req1_ready = !lastGrant;
      end else begin
        req0_ready = req0_valid;
        req1_ready = req1_valid;
      end
    end
  end

  assign accept0 = req0_valid && req0_ready;
  assign accept1 = req1_valid && req1_ready;
  assign accept  = accept0 || accept1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1Valid   <= 1'b0;
      lastGrant <= LAST_GRANT_INIT;
    end else if (!ctrl_stall) begin
      s1Valid <= accept;
      if (accept) lastGrant <= accept1;
    end
  end

  // NOTE: the stage-1 payload is deliberately not reset; it is only consumed
  // when s1Valid is set, so clearing it would add reset fan-out for nothing.
  always_ff @(posedge clock) begin
    if (accept) begin
      s1Id       <= accept1;
      s1OperandA <= accept1 ? req1_operandA  : req0_operandA;
      s1OperandB <= accept1 ? req1_operandB  : req0_operandB;
      s1Opcode   <= accept1 ? req1_ALUopcode : req0_ALUopcode;
      s1ShiftAmt <= accept1 ? req1_shiftamt  : req0_shiftamt;
    end
  end

  alu aluInst (
    .operandA   (s1OperandA),
    .operandB   (s1OperandB),
    .opcode     (s1Opcode),
    .shiftAmt   (s1ShiftAmt),
    .result     (aluResult),
    .isNotEqual (aluNotEqual),
    .isLessThan (aluLessThan),
    .overflow   (aluOverflow)
  );

  // Stage 2 is the response bus itself. The data only loads with a new
  // result, so it holds its last value between responses.
  always_ff @(posedge clock) begin
    if (reset) begin
      resp0_valid      <= 1'b0;
      resp1_valid      <= 1'b0;
      resp_data_result <= '0;
      resp_isNotEqual  <= 1'b0;
      resp_isLessThan  <= 1'b0;
      resp_overflow    <= 1'b0;
    end else if (!ctrl_stall) begin
      resp0_valid <= s1Valid && !s1Id;
      resp1_valid <= s1Valid && s1Id;
      if (s1Valid) begin
        resp_data_result <= aluResult;
        resp_isNotEqual  <= aluNotEqual;
        resp_isLessThan  <= aluLessThan;
        resp_overflow    <= aluOverflow;
      end
    end
  end

  assign busy = s1Valid || resp0_valid || resp1_valid;
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter FIRST_PRIO, default 0: requester index holding priority after reset.
REQ-002 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  request present.
REQ-005 SHALL have ports req0_operandA, req0_operandB / req1_operandA, req1_operandB  input  32  ALU operands.
REQ-006 SHALL have ports req0_ALUopcode, req0_shiftamt / req1_ALUopcode, req1_shiftamt  input  5  ALU opcode and shift amount.
REQ-007 SHALL have ports req0_ready / req1_ready  output  1  grant; the request is accepted on an edge where valid and ready are both high.
REQ-008 SHALL have port ctrl_stall  input  1  freeze: no grants, all pipeline registers hold.
REQ-009 SHALL have ports resp0_valid / resp1_valid  output  1  result for that requester is on the response bus.
REQ-010 SHALL have ports resp_data_result  output  32, resp_isNotEqual, resp_isLessThan, resp_overflow  output  1  registered, shared response bus.
REQ-011 SHALL have port busy  output  1  high while any accepted request has not yet been responded to.

Function
REQ-012 SHALL instantiate exactly one alu; no other arithmetic logic.
REQ-013 ALU opcodes SHALL be passed unmodified: 0 add, 1 sub, 2 and, 3 or, 4 sll, 5 sra; 6/7 give an undefined result, with flags still registered.
REQ-014 Arbitration SHALL be round-robin, using a last_grant register; with both requests valid, the grant SHALL go to the requester not granted last.
REQ-015 With only one request valid and ctrl_stall low, that requester SHALL be granted in the same cycle.
REQ-016 readyN SHALL be combinational from reqN_valid, last_grant, ctrl_stall and reset; at most one ready SHALL be high per cycle.
REQ-017 readyN SHALL be low while reset or ctrl_stall is high.
REQ-018 last_grant SHALL update only on an accept edge.
REQ-019 The pipeline SHALL have two stages:
  - Stage 1: operand, opcode, shamt and requester-id registers, loaded on the accept edge.
  - Stage 2: ALU output and flags, registered one edge later.
REQ-020 Latency SHALL be 2 edges: an accept at edge k SHALL make respN_valid high in the cycle after edge k+1 (absent stall).
REQ-021 Throughput SHALL be one accept per cycle; back-to-back accepts SHALL produce back-to-back responses in grant order.
REQ-022 respN_valid SHALL be a single-cycle pulse per accepted request; resp0_valid and resp1_valid SHALL never both be high.
REQ-023 The resp_* bus SHALL hold its last value while no response is valid.
REQ-024 While ctrl_stall is high, stage registers, resp_* and respN_valid SHALL hold their values (a valid response stays asserted), and last_grant SHALL hold.
REQ-025 A stage-1 valid bit and a stage-2 valid bit SHALL track occupancy; busy = stage1_valid OR stage2_valid.
REQ-026 A continuously valid requester SHALL wait at most one non-stalled cycle for a grant.

Reset
REQ-027 On reset:
  - stage valid bits, respN_valid, resp_data_result, resp_* flags and busy SHALL clear to 0.
  - last_grant SHALL be set so that FIRST_PRIO wins the first tie.
REQ-028 Reset mid-operation SHALL discard in-flight requests with no response issued; readyN SHALL be low during the reset cycle.
REQ-029 The first grant after reset SHALL occur in the first cycle with reset low.

Verification
REQ-030 Scenario: req0 add 5+7, accepted edge k -> resp0_valid pulse after edge k+1, resp_data_result=12, overflow=0.
REQ-031 Scenario: req0 and req1 both valid continuously after reset, FIRST_PRIO=0 -> grants alternate 0,1,0,1; responses alternate, each two edges after its accept.
REQ-032 Scenario: req1 sub 3-5 -> resp_data_result=0xFFFFFFFE, isNotEqual=1, isLessThan=1, overflow=0; req1 sub 9-9 -> 0, isNotEqual=0.
REQ-033 Scenario: req0 add 0x7FFFFFFF+1 -> resp_data_result=0x80000000, overflow=1; req0 sll 0x1 by 31 -> 0x80000000.
REQ-034 Scenario: ctrl_stall high for 3 cycles with both stages full -> ready low, resp held constant; after release, the remaining response follows on the next edge and none is lost or duplicated.
REQ-035 Scenario: reset asserted one cycle after accept -> no resp_valid pulse, busy=0, and the next grant goes to FIRST_PRIO.
